// File: rtl/spi_master_arb_if.sv
// Bus bundle for spi_master_arb: requester-side handshake plus the SPI pins.
// The master modport is the arbiter's view; slave is the environment's view.
interface spi_master_arb_if #(
   parameter int NREQ = 2
);
   logic [NREQ-1:0]   req;
   logic [8*NREQ-1:0] txd;
   logic [NREQ-1:0]   gnt;
   logic              busy;
   logic              done;
   logic [7:0]        rxd;
   logic              cs;
   logic              sck;
   logic              mosi;
   logic              miso;

   modport master (
      input  req, txd, miso,
      output gnt, busy, done, rxd, cs, sck, mosi
   );

   modport slave (
      output req, txd, miso,
      input  gnt, busy, done, rxd, cs, sck, mosi
   );
endinterface

// File: rtl/spi_master_arb.sv
// Round-robin arbiter in front of an 8-bit, LSB-first, mode-0 SPI master.
// One transaction per grant: IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE.
module spi_master_arb #(
   parameter int NREQ   = 2,
   parameter int CLKDIV = 2
) (
   input  logic               clk,
   input  logic               rst,
   spi_master_arb_if.master   bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int HW = $clog2(CLKDIV + 1);
   localparam logic [HW-1:0] HLAST = HW'(CLKDIV - 1);
   localparam logic [HW-1:0] HONE  = HW'(1);

   typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

   state_t            state_reg, state_next;
   logic [HW-1:0]     hcnt_reg, hcnt_next;
   logic [2:0]        bcnt_reg, bcnt_next;
   logic [6:0]        sh_reg, sh_next;
   logic [7:0]        rx_reg, rx_next;
   logic [7:0]        rxd_reg, rxd_next;
   logic              cs_reg, cs_next;
   logic              sck_reg, sck_next;
   logic              mosi_reg, mosi_next;
   logic [NREQ-1:0]   gnt_reg, gnt_next;
   logic              busy_reg, busy_next;
   logic              done_reg, done_next;
   logic [PW-1:0]     ptr_reg, ptr_next;
   logic [PW-1:0]     win_reg, win_next;

   logic [7:0]        txd_arr [NREQ];
   logic [PW-1:0]     win;
   logic              found;
   logic              hlast;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_txd
         assign txd_arr[gi] = bus.txd[8*gi +: 8];
      end
   endgenerate

   function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] p, input int off);
      int j;
      j = int'(p) + off;
      if (j >= NREQ) j = j - NREQ;
      return j[PW-1:0];
   endfunction

   // Scan from the highest offset down so the lowest offset at/after ptr wins.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (bus.req[wrap_idx(ptr_reg, i)]) begin
            found = 1'b1;
            win   = wrap_idx(ptr_reg, i);
         end
      end
   end

   assign hlast = (hcnt_reg == HLAST);

   always_comb begin
      state_next = state_reg;
      hcnt_next  = hcnt_reg;
      bcnt_next  = bcnt_reg;
      sh_next    = sh_reg;
      rx_next    = rx_reg;
      rxd_next   = rxd_reg;
      cs_next    = cs_reg;
      sck_next   = sck_reg;
      mosi_next  = mosi_reg;
      gnt_next   = gnt_reg;
      busy_next  = busy_reg;
      done_next  = 1'b0;
      ptr_next   = ptr_reg;
      win_next   = win_reg;

      unique case (state_reg)
         IDLE: begin
            hcnt_next = '0;
            if (found) begin
               win_next      = win;
               gnt_next      = '0;
               gnt_next[win] = 1'b1;
               busy_next     = 1'b1;
               cs_next       = 1'b0;
               mosi_next     = txd_arr[win][0];
               sh_next       = txd_arr[win][7:1];
               bcnt_next     = '0;
               state_next    = SETUP;
            end
         end
         SETUP: begin
            // The end of SETUP is also the first SCK rise.
            if (hlast) begin
               hcnt_next         = '0;
               sck_next          = 1'b1;
               rx_next[bcnt_reg] = bus.miso;
               state_next        = XFER;
            end else begin
               hcnt_next = hcnt_reg + HONE;
            end
         end
         XFER: begin
            if (hlast) begin
               hcnt_next = '0;
               sck_next  = ~sck_reg;
               if (!sck_reg) begin
                  rx_next[bcnt_reg] = bus.miso;
               end else if (bcnt_reg == 3'd7) begin
                  state_next = HOLD;
               end else begin
                  bcnt_next = bcnt_reg + 3'd1;
                  mosi_next = sh_reg[0];
                  sh_next   = {1'b0, sh_reg[6:1]};
               end
            end else begin
               hcnt_next = hcnt_reg + HONE;
            end
         end
         HOLD: begin
            if (hlast) begin
               hcnt_next  = '0;
               cs_next    = 1'b1;
               mosi_next  = 1'b0;
               gnt_next   = '0;
               rxd_next   = rx_reg;
               done_next  = 1'b1;
               ptr_next   = wrap_idx(win_reg, 1);
               state_next = GAP;
            end else begin
               hcnt_next = hcnt_reg + HONE;
            end
         end
         GAP: begin
            if (hlast) begin
               hcnt_next  = '0;
               busy_next  = 1'b0;
               state_next = IDLE;
            end else begin
               hcnt_next = hcnt_reg + HONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         hcnt_reg  <= '0;
         bcnt_reg  <= '0;
         sh_reg    <= '0;
         rx_reg    <= '0;
         rxd_reg   <= '0;
         cs_reg    <= 1'b1;
         sck_reg   <= 1'b0;
         mosi_reg  <= 1'b0;
         gnt_reg   <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         ptr_reg   <= '0;
         win_reg   <= '0;
      end else begin
         state_reg <= state_next;
         hcnt_reg  <= hcnt_next;
         bcnt_reg  <= bcnt_next;
         sh_reg    <= sh_next;
         rx_reg    <= rx_next;
         rxd_reg   <= rxd_next;
         cs_reg    <= cs_next;
         sck_reg   <= sck_next;
         mosi_reg  <= mosi_next;
         gnt_reg   <= gnt_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
         ptr_reg   <= ptr_next;
         win_reg   <= win_next;
      end
   end

   assign bus.cs   = cs_reg;
   assign bus.sck  = sck_reg;
   assign bus.mosi = mosi_reg;
   assign bus.gnt  = gnt_reg;
   assign bus.busy = busy_reg;
   assign bus.done = done_reg;
   assign bus.rxd  = rxd_reg;
endmodule

// File: tb/tb_spi_master_arb.sv
// Directed bench for spi_master_arb: an H=2 instance with a mode-0 slave model
// and an H=1 instance with a directly driven MISO.
module tb_spi_master_arb;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   spi_master_arb_if #(.NREQ(2)) b ();
   spi_master_arb_if #(.NREQ(2)) b1 ();

   spi_master_arb #(.NREQ(2), .CLKDIV(2)) dut (.clk(clk), .rst(rst), .bus(b.master));
   spi_master_arb #(.NREQ(2), .CLKDIV(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.master));

   // Slave model: bit index restarts on CS fall, MOSI captured on SCK rise.
   logic [7:0] s_dout = 8'h3C;
   logic [7:0] s_din  = 8'h00;
   int         s_ridx = 0;
   logic       miso1  = 1'b0;

   always @(negedge b.cs or posedge b.sck) begin
      if (!b.cs && b.sck) begin
         if (s_ridx < 8) s_din[s_ridx[2:0]] = b.mosi;
         s_ridx++;
      end else if (!b.cs) begin
         s_ridx = 0;
      end
   end

   assign b.miso  = (s_ridx < 8) ? s_dout[s_ridx[2:0]] : 1'b0;
   assign b1.miso = miso1;

   task automatic wait_done(input int start, input int budget, output int cyc,
                            output logic [1:0] g, output logic gchg);
      logic seen;
      cyc  = -1;
      g    = 2'b00;
      gchg = 1'b0;
      seen = 1'b0;
      for (int c = start; c < start + budget; c++) begin
         @(negedge clk);
         if (!b.cs && !seen) begin
            g    = b.gnt;
            seen = 1'b1;
         end else if (!b.cs && b.gnt !== g) begin
            gchg = 1'b1;
         end
         if (b.done === 1'b1) begin
            cyc = c;
            $display("txn: done cycle=%0d gnt=%b rxd=%h slave_din=%h rises=%0d", c, g, b.rxd, s_din, s_ridx);
            break;
         end
      end
      if (cyc < 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL done_timeout: no DONE within %0d cycles", budget);
      end
   endtask

   task automatic wait_idle();
      int c;
      c = 0;
      while (b.busy !== 1'b0 && c < 100) begin
         @(negedge clk);
         c++;
      end
      n_checks++;
      if (b.busy !== 1'b0) begin
         n_errors++;
         $display("FAIL idle_timeout: busy=%b required 0", b.busy);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks++;
      if ({b.cs, b.sck, b.mosi, b.gnt, b.busy, b.done} !== 7'b1000000) begin
         n_errors++;
         $display("FAIL reset_ctrl: cs,sck,mosi,gnt,busy,done=%b required 1000000",
                  {b.cs, b.sck, b.mosi, b.gnt, b.busy, b.done});
      end
      n_checks++;
      if (b.rxd !== 8'h00) begin
         n_errors++;
         $display("FAIL reset_rxd: rxd=%h required 00", b.rxd);
      end
      n_checks++;
      if ({b1.cs, b1.sck, b1.gnt, b1.busy, b1.done} !== 6'b100000) begin
         n_errors++;
         $display("FAIL reset_h1: cs,sck,gnt,busy,done=%b required 100000",
                  {b1.cs, b1.sck, b1.gnt, b1.busy, b1.done});
      end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_two_req();
      int c1, c2;
      logic [1:0] g1, g2;
      logic x1, x2;
      @(posedge clk);
      #1 b.req = 2'b11;
      b.txd = {8'h81, 8'hA5};
      @(posedge clk);
      #1 b.req = 2'b10;
      wait_done(1, 60, c1, g1, x1);
      n_checks++;
      if (g1 !== 2'b01 || x1 !== 1'b0) begin
         n_errors++;
         $display("FAIL two_first_gnt: gnt=%b changed=%b required 01 0", g1, x1);
      end
      n_checks++;
      if (s_din !== 8'hA5) begin
         n_errors++;
         $display("FAIL two_first_din: slave din=%h required a5", s_din);
      end
      wait_done(c1 + 1, 60, c2, g2, x2);
      b.req = 2'b00;
      n_checks++;
      if (g2 !== 2'b10 || c2 - c1 !== 37) begin
         n_errors++;
         $display("FAIL two_second: gnt=%b spacing=%0d required 10 37", g2, c2 - c1);
      end
      n_checks++;
      if (s_din !== 8'h81 || b.rxd !== 8'h3C) begin
         n_errors++;
         $display("FAIL two_second_data: din=%h rxd=%h required 81 3c", s_din, b.rxd);
      end
      wait_idle();
   endtask

   task automatic test_round_robin();
      int c, cprev;
      logic [1:0] g;
      logic x;
      logic [1:0] exp_g [4];
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
      @(posedge clk);
      #1 b.req = 2'b11;
      c = -1;
      for (int t = 0; t < 4; t++) begin
         wait_done(c + 1, 60, c, g, x);
         n_checks++;
         if (g !== exp_g[t]) begin
            n_errors++;
            $display("FAIL rr_gnt%0d: gnt=%b required %b", t, g, exp_g[t]);
         end
      end
      b.req = 2'b00;
      wait_idle();
      // A lone requester is re-granted back to back.
      @(posedge clk);
      #1 b.req = 2'b01;
      wait_done(0, 60, cprev, g, x);
      wait_done(cprev + 1, 60, c, g, x);
      b.req = 2'b00;
      n_checks++;
      if (g !== 2'b01 || c - cprev !== 37) begin
         n_errors++;
         $display("FAIL lone_b2b: gnt=%b spacing=%0d required 01 37", g, c - cprev);
      end
      wait_idle();
   endtask

   task automatic test_single();
      int c;
      logic [1:0] g;
      logic x;
      @(posedge clk);
      #1 b.req = 2'b01;
      b.txd = {8'h00, 8'hA5};
      @(posedge clk);
      #1 b.req = 2'b00;
      wait_done(1, 60, c, g, x);
      n_checks++;
      if (c !== 35) begin
         n_errors++;
         $display("FAIL single_done_cycle: cycle=%0d required 35", c);
      end
      n_checks++;
      if (b.rxd !== 8'h3C || s_din !== 8'hA5) begin
         n_errors++;
         $display("FAIL single_data: rxd=%h din=%h required 3c a5", b.rxd, s_din);
      end
      n_checks++;
      if (s_ridx !== 8 || g !== 2'b01 || x !== 1'b0) begin
         n_errors++;
         $display("FAIL single_bus: rises=%0d gnt=%b changed=%b required 8 01 0", s_ridx, g, x);
      end
      @(negedge clk);
      n_checks++;
      if (b.done !== 1'b0 || b.busy !== 1'b1 || b.cs !== 1'b1) begin
         n_errors++;
         $display("FAIL single_gap: done,busy,cs=%b required 011", {b.done, b.busy, b.cs});
      end
      @(negedge clk);
      n_checks++;
      if (b.busy !== 1'b0) begin
         n_errors++;
         $display("FAIL single_busy_fall: busy=%b required 0", b.busy);
      end
   endtask

   task automatic test_drop_and_txd_change();
      int c;
      logic [1:0] g;
      logic x;
      @(posedge clk);
      #1 b.req = 2'b01;
      b.txd = {8'h00, 8'h5A};
      @(posedge clk);
      #1 b.req = 2'b00;
      repeat (4) @(posedge clk);
      #1 b.txd = {8'hFF, 8'hFF};
      wait_done(5, 60, c, g, x);
      n_checks++;
      if (c !== 35 || s_din !== 8'h5A) begin
         n_errors++;
         $display("FAIL drop_txd: done cycle=%0d din=%h required 35 5a", c, s_din);
      end
      wait_idle();
   endtask

   task automatic test_reset_mid();
      int c, k;
      logic [1:0] g;
      logic x, dseen;
      @(posedge clk);
      #1 b.req = 2'b01;
      b.txd = {8'h00, 8'hA5};
      k = 0;
      while (s_ridx !== 3 && k < 100) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (s_ridx !== 3) begin
         n_errors++;
         $display("FAIL rst_wait: rises=%0d required 3", s_ridx);
      end
      rst = 1'b1;
      b.req = 2'b00;
      #1;
      n_checks++;
      if ({b.cs, b.sck, b.gnt, b.busy} !== 5'b10000 || b.rxd !== 8'h00) begin
         n_errors++;
         $display("FAIL rst_mid: cs,sck,gnt,busy=%b rxd=%h required 10000 00",
                  {b.cs, b.sck, b.gnt, b.busy}, b.rxd);
      end
      dseen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (b.done !== 1'b0) dseen = 1'b1;
      end
      n_checks++;
      if (dseen !== 1'b0) begin
         n_errors++;
         $display("FAIL rst_no_done: done seen=%b required 0", dseen);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 b.req = 2'b01;
      b.txd = {8'h00, 8'h96};
      @(posedge clk);
      #1 b.req = 2'b00;
      wait_done(1, 60, c, g, x);
      n_checks++;
      if (c !== 35 || s_din !== 8'h96 || b.rxd !== 8'h3C) begin
         n_errors++;
         $display("FAIL rst_after: cycle=%0d din=%h rxd=%h required 35 96 3c", c, s_din, b.rxd);
      end
      wait_idle();
   endtask

   task automatic run_h1(input logic m, input logic [7:0] exp_rxd);
      int dcyc, first, last, rises;
      logic prev, badp;
      dcyc = -1; first = -1; last = -1; rises = 0; prev = 1'b0; badp = 1'b0;
      miso1 = m;
      @(posedge clk);
      #1 b1.req = 2'b01;
      b1.txd = {8'h00, 8'hFF};
      @(posedge clk);
      #1 b1.req = 2'b00;
      for (int c = 1; c < 60; c++) begin
         @(negedge clk);
         if (b1.sck === 1'b1 && prev === 1'b0) begin
            if (first >= 0 && c - last !== 2) badp = 1'b1;
            if (first < 0) first = c;
            last = c;
            rises++;
         end
         prev = b1.sck;
         if (b1.done === 1'b1) begin
            dcyc = c;
            $display("txn: h1 done cycle=%0d rxd=%h rises=%0d", c, b1.rxd, rises);
            break;
         end
      end
      n_checks++;
      if (dcyc !== 18 || b1.rxd !== exp_rxd) begin
         n_errors++;
         $display("FAIL h1_done: cycle=%0d rxd=%h required 18 %h", dcyc, b1.rxd, exp_rxd);
      end
      n_checks++;
      if (rises !== 8 || first !== 2 || last !== 16 || badp !== 1'b0) begin
         n_errors++;
         $display("FAIL h1_sck: rises=%0d first=%0d last=%0d badperiod=%b required 8 2 16 0",
                  rises, first, last, badp);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_h1();
      run_h1(1'b1, 8'hFF);
      run_h1(1'b0, 8'h00);
   endtask

   initial begin
      b.req  = 2'b00;
      b.txd  = '0;
      b1.req = 2'b00;
      b1.txd = '0;
      test_reset();
      test_two_req();
      test_round_robin();
      test_single();
      test_drop_and_txd_change();
      test_reset_mid();
      test_h1();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/spi_master_arb.md
# spi_master_arb

Round-robin SPI master that shares a single SPI bus among NREQ on-chip requesters. It runs 8-bit, LSB-first, mode-0 transfers (SCK idle low, data sampled on SCK rise, changed on SCK fall) that match the codebase's spi_slave. It owns CS, SCK and MOSI, captures MISO, and returns the received byte to the granted requester with a one-cycle DONE pulse.

## Interface
Parameters:
- NREQ, 2: number of requesters, 2..8.
- CLKDIV, 2: SCK half-period H, in CLK cycles, ≥1.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  asynchronous, active-high reset.
- REQ  in  NREQ  per-requester transfer request, level.
- TXD  in  8*NREQ  byte to send; requester i uses TXD[8i+7:8i].
- GNT  out  NREQ  one-hot grant, high for the granted requester's whole transaction.
- BUSY  out  1  high from SETUP through GAP.
- DONE  out  1  one-cycle pulse; RXD is valid in the same cycle.
- RXD  out  8  last received byte; holds until the next DONE.
- CS  out  1  active-low chip select.
- SCK  out  1  serial clock.
- MOSI  out  1  serial data to the slave.
- MISO  in  1  serial data from the slave.

## Operation
- Reset values: CS=1, SCK=0, MOSI=0, GNT=0, BUSY=0, DONE=0, RXD=0x00, state IDLE, round-robin pointer selects requester 0 as highest priority.
- Reset asserted mid-transfer aborts immediately. No DONE is issued, CS rises at once, and everything returns to the reset values.
- States: IDLE → SETUP → XFER → HOLD → GAP → IDLE.
- IDLE:
  - CS=1, SCK=0.
  - If REQ≠0, pick the first requesting index at or after the pointer, wrapping modulo NREQ.
  - Latch that requester's TXD into the shift register; set GNT, BUSY, CS=0, MOSI=TXD[0]; go to SETUP.
- SETUP: hold for H cycles, SCK=0, so the slave's bit index resets on the CS fall before the first SCK rise.
- XFER: 16 half-periods of H cycles each; SCK toggles at the end of each half-period, starting with a rise.
  - On each rise k (k=0..7), MISO is sampled into rx[k] on the same CLK edge that drives SCK high.
  - On each fall k=0..6, MOSI takes TXD bit k+1 on the same edge.
  - After fall 7, MOSI holds bit 7.
- HOLD: H cycles, CS=0, SCK=0. At the end:
  - CS=1, MOSI=0, GNT=0;
  - RXD ← rx, DONE=1 for one cycle;
  - pointer ← winner+1 modulo NREQ.
- GAP: H cycles, CS=1; BUSY drops at the end; then IDLE.
- REQ and TXD are sampled only at arbitration. Changes during a transaction, including REQ dropping, are ignored and the transfer completes.
- A requester that keeps REQ high after DONE is re-granted only when no other requester is pending.
- A bit counter (0..7) and a half-period counter (0..H-1) handle width; no arithmetic beyond modulo wrap.

## Timing
- Cycle 0 is the IDLE cycle in which REQ≠0 is seen.
- State-driven outputs change at the end of the stated cycle:
  - CS falls, GNT and BUSY rise: end of cycle 0.
  - SCK rise k: end of cycle (2k+1)H. SCK fall k: end of cycle (2k+2)H.
  - Last fall: end of cycle 16H.
  - CS rises, GNT falls: end of cycle 17H.
  - DONE is high in cycle 17H+1.
  - BUSY falls at the end of cycle 18H; the next arbitration is at the earliest in cycle 18H+1.
- Transaction period is 18H+1 cycles.
- For H=1: SCK is CLK/2, and SETUP, HOLD and GAP are one cycle each.
- MOSI is stable ≥H cycles before and after every SCK rise.
- MISO must settle within H cycles after an SCK fall.

## Test plan
- H=2, NREQ=2, requester 0 sends 0xA5, spi_slave model has DOUT=0x3C.
  - Slave DIN=0xA5 and RXD=0x3C at DONE, with DONE in cycle 35.
  - Exactly 8 SCK rises while CS=0; GNT=01 throughout.
- REQ=11 asserted in the same cycle from IDLE → requester 0 served first, then requester 1 with GNT=10; two DONE pulses 37 cycles apart.
- Both REQ held high for 4 transactions → grants alternate 01,10,01,10; a lone REQ=01 held high → back-to-back grants to 0.
- RST pulsed after the 3rd SCK rise → CS=1, SCK=0, GNT=0, RXD=0x00, no DONE; the next request after reset transfers correctly.
- REQ dropped during XFER → transfer completes and DONE fires; TXD changed mid-transfer is not reflected on MOSI.
- H=1, TXD=0xFF, MISO tied 0 → RXD=0x00; SCK period is 2 cycles; DONE in cycle 18.
